// File: rtl/atanh_cordic_pkg.sv
// Shared constants for the sequential hyperbolic CORDIC atanh unit.
// Holds the fixed-point format, the iteration schedule and the FSM states.
package atanh_cordic_pkg;

    localparam int FLOAT_SIZE = 24;
    localparam int INT_SIZE   = 8;
    localparam int GUARD      = 2;

    localparam int N_ITER     = 19;
    localparam int N_REPEAT   = 2;
    localparam int IDX_FIRST_I = -3;

    localparam logic signed [4:0] IDX_FIRST = 5'(IDX_FIRST_I);
    localparam logic signed [4:0] IDX_LAST  =
        5'(IDX_FIRST_I + N_ITER - N_REPEAT - 1);
    localparam logic signed [4:0] REP_A = 5'sd4;
    localparam logic signed [4:0] REP_B = 5'sd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/atanh_LOOKUP.sv
// Combinational table of atanh(f) in Q8.24 for schedule index i = -3..13.
// Ports: idx_i = signed iteration index, val_o = atanh(f(i)); 0 outside range.
module atanh_LOOKUP
    import atanh_cordic_pkg::*;
(
    input  logic signed [4:0]                     idx_i,
    output logic signed [INT_SIZE+FLOAT_SIZE-1:0] val_o
);

    // i<=0 uses f = 1-2^(i-2); i>=1 uses f = 2^-i.
    always_comb begin
        val_o = '0;
        unique case (idx_i)
            -5'sd3: val_o = 32'sh0212_523D;
            -5'sd2: val_o = 32'sh01B7_8CE4;
            -5'sd1: val_o = 32'sh015A_A163;
            5'sd0:  val_o = 32'sh00F9_1395;
            5'sd1:  val_o = 32'sh008C_9F53;
            5'sd2:  val_o = 32'sh0041_62BB;
            5'sd3:  val_o = 32'sh0020_2B12;
            5'sd4:  val_o = 32'sh0010_0558;
            5'sd5:  val_o = 32'sh0008_00AA;
            5'sd6:  val_o = 32'sh0004_0015;
            5'sd7:  val_o = 32'sh0002_0002;
            5'sd8:  val_o = 32'sh0001_0000;
            5'sd9:  val_o = 32'sh0000_8000;
            5'sd10: val_o = 32'sh0000_4000;
            5'sd11: val_o = 32'sh0000_2000;
            5'sd12: val_o = 32'sh0000_1000;
            5'sd13: val_o = 32'sh0000_0800;
            default: val_o = '0;
        endcase
    end

endmodule

// File: rtl/atanh_cordic.sv
// Sequential hyperbolic CORDIC (vectoring) computing atanh(r), one step/clock.
// Ports: in_valid/in_ready/in_r operand handshake (Q8.24); out_valid/out_ready
// result handshake with out_z = atanh(r) (Q8.24) and out_err for |r| >= 1.
module atanh_cordic #(
    parameter int FLOAT_SIZE = atanh_cordic_pkg::FLOAT_SIZE,
    parameter int INT_SIZE   = atanh_cordic_pkg::INT_SIZE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [INT_SIZE+FLOAT_SIZE-1:0] in_r,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [INT_SIZE+FLOAT_SIZE-1:0] out_z,
    output logic                                 out_err
);

    import atanh_cordic_pkg::*;

    localparam int W  = INT_SIZE + FLOAT_SIZE;
    localparam int WI = W + GUARD;

    localparam logic signed [W-1:0]  ONE_W = W'(1) << FLOAT_SIZE;
    localparam logic signed [WI-1:0] ONE_I = WI'(1) << FLOAT_SIZE;

    state_e state_q, state_d;

    logic signed [WI-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [4:0]    idx_q, idx_d;
    logic                 rep_q, rep_d;
    logic                 err_q, err_d;
    logic                 neg_q, neg_d;
    logic                 zero_q, zero_d;

    logic signed [W-1:0]  lut_z;
    logic signed [WI-1:0] ang;
    logic [4:0]           sh;
    logic                 low_idx;
    logic signed [WI-1:0] xs, ys, fx, fy;
    logic signed [W-1:0]  r_abs;
    logic                 in_err;
    logic signed [W-1:0]  z_res;
    logic                 z_unused;

    atanh_LOOKUP u_lut (
        .idx_i (idx_q),
        .val_o (lut_z)
    );

    assign ang = WI'(lut_z);

    // f*v for i<=0 is v - (v >>> (2-i)); for i>=1 it is v >>> i.
    assign low_idx = (idx_q <= 5'sd0);
    assign sh      = low_idx ? $unsigned(5'sd2 - idx_q) : $unsigned(idx_q);
    assign xs      = x_q >>> sh;
    assign ys      = y_q >>> sh;
    assign fx      = low_idx ? (x_q - xs) : xs;
    assign fy      = low_idx ? (y_q - ys) : ys;

    assign in_err = (in_r >= ONE_W) || (in_r <= -ONE_W);

    // Iterate on |r| and restore the sign at the output so that
    // atanh(-r) is the exact negation of atanh(r).
    assign r_abs = in_r[W-1] ? -in_r : in_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            idx_q   <= '0;
            rep_q   <= 1'b0;
            err_q   <= 1'b0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            err_q   <= err_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        err_d   = err_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = ONE_I;
                    y_d     = WI'(r_abs);
                    z_d     = '0;
                    idx_d   = IDX_FIRST;
                    rep_d   = 1'b0;
                    err_d   = in_err;
                    neg_d   = in_r[W-1];
                    zero_d  = (in_r == '0);
                    state_d = RUN;
                end
            end
            RUN: begin
                // Pointer past the last index: all 19 steps are done.
                if (idx_q > IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    if (!y_q[WI-1]) begin
                        x_d = x_q - fy;
                        y_d = y_q - fx;
                        z_d = z_q + ang;
                    end else begin
                        x_d = x_q + fy;
                        y_d = y_q + fx;
                        z_d = z_q - ang;
                    end
                    if ((idx_q == REP_A || idx_q == REP_B) && !rep_q) begin
                        rep_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'sd1;
                        rep_d = 1'b0;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign z_res    = z_q[W-1:0];
    assign z_unused = ^z_q[WI-1:W];

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_err   = (state_q == DONE) && err_q;
    assign out_z     = ((state_q == DONE) && !err_q && !zero_q)
                     ? (neg_q ? -z_res : z_res) : '0;

endmodule

// File: tb/tb_atanh_cordic.sv
// Self-checking bench for atanh_cordic: real-valued atanh model plus
// directed vectors with hand-computed literals.
module tb_atanh_cordic;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_r;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        out_err;

    int checks = 0;
    int passes = 0;

    atanh_cordic dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act,
                       input longint exp, input longint tol);
        checks++;
        if (act > exp + tol || act < exp - tol)
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) +/- %0d",
                     name, act, act, exp, exp, tol);
        else
            passes++;
    endtask

    // Expected result from the mathematical definition of atanh.
    function automatic void model(input logic [31:0] r, output longint z,
                                  output longint e, output longint tol);
        longint ri;
        real    rr;
        real    a;
        ri = longint'($signed(r));
        e  = ((ri >= 64'sd16777216) || (ri <= -64'sd16777216)) ? 1 : 0;
        if (e != 0 || ri == 0) begin
            z   = 0;
            tol = 0;
        end else begin
            rr  = real'(ri) / 16777216.0;
            a   = 0.5 * $ln((1.0 + rr) / (1.0 - rr));
            z   = longint'($rtoi(a * 16777216.0));
            tol = 'hC00;
        end
    endfunction

    // Compare process: tracks the expected handshake timeline and result.
    bit     busy = 0;
    int     cnt  = 0;
    longint m_z, m_e, m_tol;
    longint held_z, held_e;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", in_ready, 1, 0);
            chk("rst_out_valid", out_valid, 0, 0);
            chk("rst_out_z", $signed(out_z), 0, 0);
            chk("rst_out_err", out_err, 0, 0);
            busy = 0;
        end else if (!busy) begin
            chk("idle_in_ready", in_ready, 1, 0);
            chk("idle_out_valid", out_valid, 0, 0);
            if (in_valid) begin
                busy = 1;
                cnt  = -1;
                model(in_r, m_z, m_e, m_tol);
            end
        end else begin
            cnt++;
            chk("busy_in_ready", in_ready, 0, 0);
            chk("out_valid_timing", out_valid, (cnt >= 20) ? 1 : 0, 0);
            if (cnt >= 20) begin
                if (cnt == 20) begin
                    chk("model_z", $signed(out_z), m_z, m_tol);
                    chk("model_err", out_err, m_e, 0);
                    held_z = $signed(out_z);
                    held_e = out_err;
                end else begin
                    chk("held_z", $signed(out_z), held_z, 0);
                    chk("held_err", out_err, held_e, 0);
                end
                if (out_ready) busy = 0;
            end
        end
    end

    task automatic run_op(input logic [31:0] r, input int hold,
                          input bit poke, output logic [31:0] z,
                          output logic e);
        int n;
        @(posedge clk); #2;
        in_valid = 1'b1;
        in_r     = r;
        @(posedge clk); #2;
        in_valid = 1'b0;
        in_r     = '0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        chk("latency", n, 20, 0);
        z = out_z;
        e = out_err;
        if (poke) begin
            in_valid = 1'b1;
            in_r     = 32'h0040_0000;
        end
        repeat (hold) @(posedge clk);
        #2;
        in_valid = 1'b0;
        if (hold > 0) begin
            chk("hold_z", $signed(out_z), $signed(z), 0);
            chk("hold_valid", out_valid, 1, 0);
            chk("hold_in_ready", in_ready, 0, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        chk("release_in_ready", in_ready, 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] zp, zn, z;
        logic        e;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_r      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_in_ready", in_ready, 1, 0);
        chk("reset_out_valid", out_valid, 0, 0);
        chk("reset_out_z", $signed(out_z), 0, 0);
        chk("reset_out_err", out_err, 0, 0);
        rst = 1'b0;

        run_op(32'h0080_0000, 0, 0, zp, e);
        chk("half_z", $signed(zp), 64'sh8c9f54, 'hC00);
        chk("half_err", e, 0, 0);

        run_op(32'hFF80_0000, 0, 0, zn, e);
        chk("mhalf_z", $signed(zn), -64'sh8c9f54, 'hC00);
        chk("sym_half", longint'($signed(zp)) + longint'($signed(zn)), 0, 1);

        run_op(32'h0000_0000, 0, 0, z, e);
        chk("zero_z", $signed(z), 0, 0);
        chk("zero_err", e, 0, 0);

        run_op(32'h00F8_0000, 0, 0, zp, e);
        chk("edge_z", $signed(zp), 64'sh0212523d, 'hC00);
        run_op(32'hFF08_0000, 0, 0, zn, e);
        chk("sym_edge", longint'($signed(zp)) + longint'($signed(zn)), 0, 1);

        run_op(32'h0100_0000, 0, 0, z, e);
        chk("pos_one_err", e, 1, 0);
        chk("pos_one_z", $signed(z), 0, 0);
        run_op(32'hFF00_0000, 0, 0, z, e);
        chk("neg_one_err", e, 1, 0);
        chk("neg_one_z", $signed(z), 0, 0);
        run_op(32'h8000_0000, 0, 0, z, e);
        chk("min_err", e, 1, 0);

        run_op(32'h00C0_0000, 0, 0, z, e);
        run_op(32'hFF40_0000, 0, 0, z, e);

        run_op(32'h0010_0000, 10, 1, z, e);
        chk("stall_z", $signed(z), 64'sh100558, 'hC00);

        @(posedge clk); #2;
        in_valid = 1'b1;
        in_r     = 32'h00C0_0000;
        @(posedge clk); #2;
        in_valid = 1'b0;
        in_r     = '0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1, 0);
        chk("abort_out_valid", out_valid, 0, 0);
        chk("abort_out_z", $signed(out_z), 0, 0);
        chk("abort_out_err", out_err, 0, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #2;
        chk("no_result_after_abort", out_valid, 0, 0);

        run_op(32'h0040_0000, 0, 0, z, e);
        chk("quarter_z", $signed(z), 64'sh4162bc, 'hC00);
        chk("quarter_err", e, 0, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
